triangle_fifo_reader: RTL

- Consumer side of triangle_fifo: pops one triangle at a time and streams its three vertices, one per handshake, to the downstream rasterizer setup stage over valid/ready.
- Each triangle is held locally until all three vertices are accepted; the FIFO is popped only when the held triangle is finished.
- Sits between triangle_fifo (fed by the transform stage) and the rasterizer.

---
 rtl/triangle_fifo_reader_if.sv | 27 ++
 rtl/triangle_fifo_reader.sv | 95 +++++++++
 2 files changed

// File: rtl/triangle_fifo_reader_if.sv
// Handshake bundle for triangle_fifo_reader: FIFO read side plus the vertex
// stream toward rasterizer setup. master = reader, slave = FIFO/downstream.
interface triangle_fifo_reader_if #(
  parameter int WI = 2,
  parameter int WF = 2
);
  localparam int W = WI + WF;

  logic                     fifo_empty;
  logic                     fifo_r_en;
  logic [2:0][2:0][W-1:0]   fifo_triangle;
  logic                     vtx_valid;
  logic                     vtx_ready;
  logic [2:0][W-1:0]        vtx;
  logic [1:0]               vtx_idx;
  logic                     tri_last;

  modport master (
    input  fifo_empty, fifo_triangle, vtx_ready,
    output fifo_r_en, vtx_valid, vtx, vtx_idx, tri_last
  );

  modport slave (
    output fifo_empty, fifo_triangle, vtx_ready,
    input  fifo_r_en, vtx_valid, vtx, vtx_idx, tri_last
  );
endinterface

// File: rtl/triangle_fifo_reader.sv
// Pops one triangle from triangle_fifo, holds it, and streams its three
// vertices downstream over valid/ready. All outputs are registered.
module triangle_fifo_reader #(
  parameter int WI   = 2,
  parameter int WF   = 2,
  parameter int CNTW = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  triangle_fifo_reader_if.master  bus,
  output logic [CNTW-1:0]         tri_count,
  output logic                    busy
);
  localparam int W = WI + WF;

  typedef enum logic [1:0] {IDLE, REQ, CAPT, SEND} state_t;

  state_t                  state_q, state_d;
  logic [2:0][2:0][W-1:0]  held_q, held_d;
  logic [1:0]              idx_q, idx_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic                    r_en_q, r_en_d;
  logic                    valid_q, valid_d;
  logic [2:0][W-1:0]       vtx_q, vtx_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (!bus.fifo_empty) state_d = REQ;
      REQ:  state_d = CAPT;
      CAPT: begin
        held_d  = bus.fifo_triangle;
        idx_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (bus.vtx_ready) begin
          if (idx_q == 2'd2) begin
            cnt_d   = cnt_q + CNTW'(1);
            idx_d   = 2'd0;
            state_d = bus.fifo_empty ? IDLE : REQ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so they register in step
    // with the state, keeping vtx_ready off any combinational output path.
    r_en_d  = (state_d == REQ);
    valid_d = (state_d == SEND);
    vtx_d   = valid_d ? held_d[idx_d] : '0;
    last_d  = valid_d && (idx_d == 2'd2);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      r_en_q  <= 1'b0;
      valid_q <= 1'b0;
      vtx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      r_en_q  <= r_en_d;
      valid_q <= valid_d;
      vtx_q   <= vtx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.fifo_r_en = r_en_q;
  assign bus.vtx_valid = valid_q;
  assign bus.vtx       = vtx_q;
  assign bus.vtx_idx   = idx_q;
  assign bus.tri_last  = last_q;
  assign tri_count     = cnt_q;
  assign busy          = busy_q;
endmodule
